// File: rtl/ufm_arb_pkg.sv
// ---------------------------------------------------------------------------
// ufm_arb_pkg
// Purpose : shared types and helpers for the UFM read arbiter.
//   - arb_state_t      : arbiter FSM encoding (2 bits)
//   - PAGE_LEN_DEFAULT : bytes per UFM page read
//   - clog2_min1       : ceil(log2(v)), never less than 1 (safe vector width)
// Ports   : none (package)
// ---------------------------------------------------------------------------
package ufm_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_XFER  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  localparam int PAGE_LEN_DEFAULT = 16;

  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ufm_arb_pick.sv
// ---------------------------------------------------------------------------
// ufm_arb_pick
// Purpose : combinational winner selection for the UFM read arbiter.
//   Default: rotating priority, search starts at i_ptr, first requester wins.
//   With UFM_ARB_FIXED_PRIO_EN defined: lowest-index requester always wins
//   and i_ptr is ignored.
// Ports   :
//   i_req  [NUM_REQ-1:0]  request vector
//   i_ptr  [PTR_W-1:0]    index with highest priority this contest
//   o_gnt  [NUM_REQ-1:0]  one-hot winner (all zero when no request)
// Macro   : UFM_ARB_FIXED_PRIO_EN
// ---------------------------------------------------------------------------
module ufm_arb_pick #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt
);

`ifdef UFM_ARB_FIXED_PRIO_EN

  logic w_ptr_unused;
  assign w_ptr_unused = ^i_ptr;

  always_comb begin
    logic found;
    found = 1'b0;
    o_gnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && i_req[i]) begin
        o_gnt[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

`else

  // Walk the ring starting at the pointer; the first requester met wins.
  always_comb begin
    logic found;
    int   idx;
    found = 1'b0;
    idx   = 0;
    o_gnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(i_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && i_req[idx]) begin
        o_gnt[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

`endif

endmodule

// File: rtl/ufm_read_arbiter.sv
// ---------------------------------------------------------------------------
// ufm_read_arbiter
// Purpose : shares one ufm_reader between NUM_REQ clients. Grants one whole
//   PAGE_LEN-byte page read at a time, pulses rd_start to the reader with the
//   latched page address, fans data/strobes back to the granted client only
//   and forwards that client's stall.
//
//   state | meaning
//   IDLE  | waiting for rd_ready and any request; contest runs here
//   START | grant held, rd_start pulse being issued
//   XFER  | counting reader strobes until PAGE_LEN bytes delivered
//   DONE  | page_done pulse to winner, release grant, advance pointer
//
// Ports :
//   clk, rst          clock, synchronous active-high reset
//   i_req             per-client page request (held until page_done)
//   i_req_addr        flattened page addresses, slice i = [i*ADDR_W +: ADDR_W]
//   i_req_stall       per-client back-pressure
//   o_gnt             one-hot grant (registered)
//   o_cl_data         read byte shared by all clients
//   o_cl_data_stb     per-client byte strobe (granted client only, in XFER)
//   o_page_done       one-cycle pulse to the winner after its last byte
//   o_busy            high from grant through page_done
//   o_rd_start        one-cycle start pulse to ufm_reader
//   o_rd_addr         latched page address for ufm_reader
//   o_rd_stall        stall of the granted client
//   i_rd_data         reader byte
//   i_rd_data_stb     reader byte strobe
//   i_rd_ready        reader idle
// Macro : UFM_ARB_FIXED_PRIO_EN selects fixed lowest-index priority.
// ---------------------------------------------------------------------------
module ufm_read_arbiter
  import ufm_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 8,
  parameter int PAGE_LEN = PAGE_LEN_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ-1:0]        i_req_stall,
  output logic [NUM_REQ-1:0]        o_gnt,
  output logic [DATA_W-1:0]         o_cl_data,
  output logic [NUM_REQ-1:0]        o_cl_data_stb,
  output logic [NUM_REQ-1:0]        o_page_done,
  output logic                      o_busy,
  output logic                      o_rd_start,
  output logic [ADDR_W-1:0]         o_rd_addr,
  output logic                      o_rd_stall,
  input  logic [DATA_W-1:0]         i_rd_data,
  input  logic                      i_rd_data_stb,
  input  logic                      i_rd_ready
);

  localparam int PTR_W = clog2_min1(NUM_REQ);
  localparam int CNT_W = clog2_min1(PAGE_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAGE_LEN - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  arb_state_t          r_state;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [NUM_REQ-1:0]  r_page_done;
  logic                r_busy;
  logic                r_rd_start;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [CNT_W-1:0]    r_cnt;
  logic [PTR_W-1:0]    r_ptr;
  logic [PTR_W-1:0]    r_win;

  logic [NUM_REQ-1:0]  w_pick;
  logic [PTR_W-1:0]    w_pick_idx;
  logic [ADDR_W-1:0]   w_pick_addr;
  logic [PTR_W-1:0]    w_ptr_next;

  ufm_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_gnt (w_pick)
  );

  // One-hot winner to index and address; w_pick is one-hot so OR-ing is a mux.
  always_comb begin
    w_pick_idx  = '0;
    w_pick_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick[i]) begin
        w_pick_idx  = PTR_W'(i);
        w_pick_addr = w_pick_addr | i_req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign w_ptr_next = (r_win == PTR_LAST) ? '0 : r_win + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_gnt       <= '0;
      r_page_done <= '0;
      r_busy      <= 1'b0;
      r_rd_start  <= 1'b0;
      r_rd_addr   <= '0;
      r_cnt       <= '0;
      r_ptr       <= '0;
      r_win       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_rd_ready && (|i_req)) begin
            r_gnt     <= w_pick;
            r_win     <= w_pick_idx;
            r_rd_addr <= w_pick_addr;
            r_busy    <= 1'b1;
            r_state   <= ST_START;
          end
        end
        ST_START: begin
          r_rd_start <= 1'b1;
          r_state    <= ST_XFER;
        end
        ST_XFER: begin
          r_rd_start <= 1'b0;
          if (i_rd_data_stb) begin
            if (r_cnt == CNT_LAST) begin
              // page_done rises with DONE so busy/gnt still cover it
              r_cnt       <= '0;
              r_page_done <= r_gnt;
              r_state     <= ST_DONE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        ST_DONE: begin
          r_page_done <= '0;
          r_gnt       <= '0;
          r_busy      <= 1'b0;
          r_ptr       <= w_ptr_next;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_gnt         = r_gnt;
  assign o_page_done   = r_page_done;
  assign o_busy        = r_busy;
  assign o_rd_start    = r_rd_start;
  assign o_rd_addr     = r_rd_addr;
  assign o_cl_data     = i_rd_data;
  // Strobes outside XFER are stray and must not reach any client.
  assign o_cl_data_stb = (r_state == ST_XFER && i_rd_data_stb) ? r_gnt : '0;
  assign o_rd_stall    = |(i_req_stall & r_gnt);

endmodule

// File: tb/tb_ufm_read_arbiter.sv
module tb_ufm_read_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [21:0] req_addr;
  logic [1:0]  req_stall;
  logic [1:0]  gnt;
  logic [7:0]  cl_data;
  logic [1:0]  cl_data_stb;
  logic [1:0]  page_done;
  logic        busy;
  logic        rd_start;
  logic [10:0] rd_addr;
  logic        rd_stall;
  logic [7:0]  rd_data;
  logic        rd_data_stb;
  logic        rd_ready;

  int n_vec  = 0;
  int n_miss = 0;

  ufm_read_arbiter #(
    .NUM_REQ  (2),
    .ADDR_W   (11),
    .DATA_W   (8),
    .PAGE_LEN (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_req         (req),
    .i_req_addr    (req_addr),
    .i_req_stall   (req_stall),
    .o_gnt         (gnt),
    .o_cl_data     (cl_data),
    .o_cl_data_stb (cl_data_stb),
    .o_page_done   (page_done),
    .o_busy        (busy),
    .o_rd_start    (rd_start),
    .o_rd_addr     (rd_addr),
    .o_rd_stall    (rd_stall),
    .i_rd_data     (rd_data),
    .i_rd_data_stb (rd_data_stb),
    .i_rd_ready    (rd_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic [10:0] a0;
    logic [10:0] a1;
    int          idx;
    logic [10:0] exp_addr;
    int          stall_at;
    int          stall_len;
  } vec_t;

  vec_t tv[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One full page: request, grant, start, PAGE_LEN strobes, page_done, release.
  // Called at a negedge with the arbiter idle; returns at a negedge in IDLE.
  task automatic do_page(input logic [1:0] req_v, input logic [10:0] a0, input logic [10:0] a1,
                         input int idx, input logic [10:0] exp_addr,
                         input int stall_at, input int stall_len);
    logic [1:0] oh;
    logic [7:0] d;
    int waited;
    oh = 2'b01 << idx;
    req = req_v;
    req_addr = {a1, a0};
    waited = 0;
    forever begin
      @(negedge clk);
      waited++;
      if (gnt != 2'b00 || waited >= 40) break;
    end
    chk("gnt_latency", waited, 1);
    chk("gnt", {30'd0, gnt}, {30'd0, oh});
    chk("busy_on_grant", {31'd0, busy}, 1);
    chk("rd_start_early", {31'd0, rd_start}, 0);
    // Address must already be latched; a stray strobe in START is ignored.
    req_addr = ~req_addr;
    rd_data_stb = 1'b1;
    #1 chk("stb_in_start", {30'd0, cl_data_stb}, 0);
    @(negedge clk);
    rd_data_stb = 1'b0;
    chk("rd_start", {31'd0, rd_start}, 1);
    chk("rd_addr", {21'd0, rd_addr}, {21'd0, exp_addr});
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("page_done_early", {30'd0, page_done}, 0);
      if (k == 0) chk("rd_start_once", {31'd0, rd_start}, 0);
      if (k == stall_at) begin
        rd_data_stb = 1'b0;
        req_stall = 2'b11;
        for (int s = 0; s < stall_len; s++) begin
          #1 chk("rd_stall_on", {31'd0, rd_stall}, 1);
          chk("stb_during_stall", {30'd0, cl_data_stb}, 0);
          @(negedge clk);
        end
        req_stall = ~oh;
        #1 chk("rd_stall_other", {31'd0, rd_stall}, 0);
        chk("page_done_stall", {30'd0, page_done}, 0);
        req_stall = 2'b00;
      end
      d = exp_addr[7:0] + 8'(k);
      rd_data = d;
      rd_data_stb = 1'b1;
      #1 chk("cl_data_stb", {30'd0, cl_data_stb}, {30'd0, oh});
      chk("cl_data", {24'd0, cl_data}, {24'd0, d});
    end
    @(negedge clk);
    chk("page_done", {30'd0, page_done}, {30'd0, oh});
    chk("busy_at_done", {31'd0, busy}, 1);
    chk("gnt_at_done", {30'd0, gnt}, {30'd0, oh});
    chk("rd_addr_hold", {21'd0, rd_addr}, {21'd0, exp_addr});
    #1 chk("stb_in_done", {30'd0, cl_data_stb}, 0);
    @(negedge clk);
    rd_data_stb = 1'b0;
    chk("page_done_clear", {30'd0, page_done}, 0);
    chk("gnt_release", {30'd0, gnt}, 0);
    chk("busy_release", {31'd0, busy}, 0);
  endtask

  initial begin
    int waited;

    tv[0] = '{req: 2'b01, a0: 11'd2042, a1: 11'd0,   idx: 0, exp_addr: 11'd2042, stall_at: -1, stall_len: 0};
    tv[1] = '{req: 2'b10, a0: 11'd0,    a1: 11'd5,   idx: 1, exp_addr: 11'd5,    stall_at: 5,  stall_len: 10};
    tv[2] = '{req: 2'b11, a0: 11'd100,  a1: 11'd200, idx: 0, exp_addr: 11'd100,  stall_at: -1, stall_len: 0};
`ifdef UFM_ARB_FIXED_PRIO_EN
    tv[3] = '{req: 2'b11, a0: 11'd101,  a1: 11'd201, idx: 0, exp_addr: 11'd101,  stall_at: -1, stall_len: 0};
    tv[4] = '{req: 2'b11, a0: 11'd102,  a1: 11'd202, idx: 0, exp_addr: 11'd102,  stall_at: -1, stall_len: 0};
    tv[5] = '{req: 2'b11, a0: 11'd103,  a1: 11'd203, idx: 0, exp_addr: 11'd103,  stall_at: -1, stall_len: 0};
`else
    tv[3] = '{req: 2'b11, a0: 11'd101,  a1: 11'd201, idx: 1, exp_addr: 11'd201,  stall_at: -1, stall_len: 0};
    tv[4] = '{req: 2'b11, a0: 11'd102,  a1: 11'd202, idx: 0, exp_addr: 11'd102,  stall_at: -1, stall_len: 0};
    tv[5] = '{req: 2'b11, a0: 11'd103,  a1: 11'd203, idx: 1, exp_addr: 11'd203,  stall_at: 0,  stall_len: 3};
`endif
    tv[6] = '{req: 2'b10, a0: 11'd0,    a1: 11'd7,   idx: 1, exp_addr: 11'd7,    stall_at: -1, stall_len: 0};
    tv[7] = '{req: 2'b11, a0: 11'd50,   a1: 11'd60,  idx: 0, exp_addr: 11'd50,   stall_at: -1, stall_len: 0};

    rst = 1'b1;
    req = 2'b00;
    req_addr = '0;
    req_stall = 2'b00;
    rd_data = 8'h00;
    rd_data_stb = 1'b0;
    rd_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_gnt", {30'd0, gnt}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_page_done", {30'd0, page_done}, 0);
    chk("rst_rd_start", {31'd0, rd_start}, 0);
    chk("rst_rd_addr", {21'd0, rd_addr}, 0);
    chk("rst_rd_stall", {31'd0, rd_stall}, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      do_page(tv[v].req, tv[v].a0, tv[v].a1, tv[v].idx, tv[v].exp_addr,
              tv[v].stall_at, tv[v].stall_len);
    end
    req = 2'b00;

    // Reader busy: no grant and no start while rd_ready is low.
    rd_ready = 1'b0;
    req = 2'b01;
    req_addr = {11'd0, 11'd333};
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("ready_low_gnt", {30'd0, gnt}, 0);
      chk("ready_low_start", {31'd0, rd_start}, 0);
    end
    rd_ready = 1'b1;
    do_page(2'b01, 11'd333, 11'd0, 0, 11'd333, -1, 0);
    req = 2'b00;

    // Stray strobes in IDLE reach nobody and do not advance the byte count.
    rd_data_stb = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1 chk("stray_idle_stb", {30'd0, cl_data_stb}, 0);
      chk("stray_idle_gnt", {30'd0, gnt}, 0);
    end
    @(negedge clk);
    rd_data_stb = 1'b0;
    do_page(2'b10, 11'd0, 11'd1500, 1, 11'd1500, -1, 0);
    req = 2'b00;

    // Reset after byte 7: everything clears, no page_done, fresh count afterwards.
    req = 2'b01;
    req_addr = {11'd0, 11'd300};
    waited = 0;
    forever begin
      @(negedge clk);
      waited++;
      if (gnt != 2'b00 || waited >= 40) break;
    end
    chk("mid_gnt", {30'd0, gnt}, 2'b01);
    @(negedge clk);
    chk("mid_rd_start", {31'd0, rd_start}, 1);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      rd_data_stb = 1'b1;
      rd_data = 8'(k);
    end
    @(negedge clk);
    rd_data_stb = 1'b0;
    rst = 1'b1;
    req = 2'b00;
    @(negedge clk);
    chk("mid_rst_gnt", {30'd0, gnt}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_page_done", {30'd0, page_done}, 0);
    chk("mid_rst_rd_addr", {21'd0, rd_addr}, 0);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_page_done", {30'd0, page_done}, 0);
    end
    do_page(2'b01, 11'd301, 11'd0, 0, 11'd301, -1, 0);
    req = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
